// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// the default miss watchdog limit and the stage-control bundle with its
// canonical patterns.
package pipe_ctrl_pkg;

  localparam int unsigned MISS_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IMISS = 2'd1,
    ST_DMISS = 2'd2
  } state_e;

  // Stage-register controls for one cycle.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic ex_mem_we;
    logic mem_wb_we;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctl_t;

  // Everything advances.
  localparam ctl_t CTL_GO       = '{pc_we: 1'b1, if_id_we: 1'b1, ex_mem_we: 1'b1,
                                    mem_wb_we: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  // Whole pipeline frozen behind a data-cache miss.
  localparam ctl_t CTL_FREEZE   = '{pc_we: 1'b0, if_id_we: 1'b0, ex_mem_we: 1'b0,
                                    mem_wb_we: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  // Taken branch: redirect PC, kill the two younger instructions.
  localparam ctl_t CTL_REDIRECT = '{pc_we: 1'b1, if_id_we: 1'b1, ex_mem_we: 1'b1,
                                    mem_wb_we: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b1};
  // Load-use: hold PC and IF/ID, push a bubble into EX.
  localparam ctl_t CTL_LU       = '{pc_we: 1'b0, if_id_we: 1'b0, ex_mem_we: 1'b1,
                                    mem_wb_we: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  // Instruction fetch outstanding: hold PC, feed a NOP into ID.
  localparam ctl_t CTL_FETCH    = '{pc_we: 1'b0, if_id_we: 1'b1, ex_mem_we: 1'b1,
                                    mem_wb_we: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b0};
  // Reset / illegal state: nothing written, NOPs loaded into IF/ID and ID/EX.
  localparam ctl_t CTL_RESET    = '{pc_we: 1'b0, if_id_we: 1'b0, ex_mem_we: 1'b0,
                                    mem_wb_we: 1'b0, if_id_flush: 1'b1, id_ex_bubble: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count up while enabled, stick at all-ones.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates data-cache miss, taken branch,
// load-use and instruction-cache miss (in that priority) into stage-register
// write enables, flush and bubble controls, with a sticky miss watchdog.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds four 16-bit saturating
// performance counters and their ports.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned MISS_TIMEOUT = MISS_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_hit,
  input  logic              dcache_hit,
  input  logic              mem_access,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              branch_taken,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              ex_mem_we,
  output logic              mem_wb_we,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        state,
  output logic              miss_fault
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_imiss_cyc,
  output logic [15:0]       perf_dmiss_cyc,
  output logic [15:0]       perf_lu_stall,
  output logic [15:0]       perf_flush
`endif
);

  localparam int unsigned WD_W = $clog2(MISS_TIMEOUT + 1);

  state_e          state_q, state_d;
  ctl_t            ctl;
  logic            load_use;
  logic            dmiss_new;
  logic            in_miss_d;
  logic [WD_W-1:0] wd_cnt;
  logic            miss_fault_q;

  assign load_use  = ex_mem_read && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign dmiss_new = mem_access && !dcache_hit;

  // State register; reset abandons any outstanding miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority arbitration of hazards into next state and stage controls.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ctl     = CTL_GO;
    case (state_q)
      ST_RUN, ST_IMISS: begin
        if (dmiss_new) begin
          ctl     = CTL_FREEZE;
          state_d = ST_DMISS;
        end else if (branch_taken) begin
          // Redirect also abandons any wrong-path fetch still outstanding.
          ctl     = CTL_REDIRECT;
          state_d = ST_RUN;
        end else if (load_use) begin
          // One-cycle stall; an outstanding fetch stays outstanding.
          ctl     = CTL_LU;
        end else if (!icache_hit) begin
          ctl     = CTL_FETCH;
          state_d = ST_IMISS;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DMISS: begin
        // Hit cycle releases everything; younger hazards are seen next cycle.
        if (dcache_hit) begin
          state_d = ST_RUN;
        end else begin
          ctl     = CTL_FREEZE;
        end
      end
      default: begin
        ctl     = CTL_RESET;
        state_d = ST_RUN;
      end
    endcase
    if (!rst_n) begin
      ctl = CTL_RESET;
    end
  end

  assign in_miss_d = (state_d != ST_RUN);

  // Consecutive miss cycles, counted as the FSM stays in (or enters) a miss.
  sat_counter #(.WIDTH(WD_W)) u_wd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!in_miss_d),
    .en_i  (in_miss_d),
    .cnt_o (wd_cnt)
  );

  // Sticky fault: raised as the counter steps onto MISS_TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_fault_q <= 1'b0;
    end else if (in_miss_d && (wd_cnt == WD_W'(MISS_TIMEOUT - 1))) begin
      miss_fault_q <= 1'b1;
    end
  end

  assign pc_we        = ctl.pc_we;
  assign if_id_we     = ctl.if_id_we;
  assign ex_mem_we    = ctl.ex_mem_we;
  assign mem_wb_we    = ctl.mem_wb_we;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_bubble = ctl.id_ex_bubble;
  assign state        = state_q;
  assign miss_fault   = miss_fault_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic lu_stall;
  assign lu_stall = rst_n && (ctl == CTL_LU);

  sat_counter #(.WIDTH(16)) u_perf_imiss (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(state_q == ST_IMISS), .cnt_o(perf_imiss_cyc)
  );
  sat_counter #(.WIDTH(16)) u_perf_dmiss (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(state_q == ST_DMISS), .cnt_o(perf_dmiss_cyc)
  );
  sat_counter #(.WIDTH(16)) u_perf_lu (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(lu_stall), .cnt_o(perf_lu_stall)
  );
  sat_counter #(.WIDTH(16)) u_perf_flush (
    .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
    .en_i(ctl.if_id_flush), .cnt_o(perf_flush)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by randomized traffic, all compared against a priority-rule model.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 8;

  // Expected control vectors {pc, if_id, ex_mem, mem_wb, flush, bubble}.
  localparam logic [5:0] E_GO     = 6'b111100;
  localparam logic [5:0] E_FREEZE = 6'b000000;
  localparam logic [5:0] E_REDIR  = 6'b111111;
  localparam logic [5:0] E_LU     = 6'b001101;
  localparam logic [5:0] E_FETCH  = 6'b011110;
  localparam logic [5:0] E_RESET  = 6'b000011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       icache_hit, dcache_hit, mem_access, ex_mem_read, branch_taken;
  logic [2:0] ex_rd, id_rs1, id_rs2;
  logic       pc_we, if_id_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble;
  logic [1:0] state;
  logic       miss_fault;

  int total = 0;
  int bad   = 0;

  // Reference model: what the pipeline is waiting for (0 nothing,
  // 1 instruction fetch, 2 data access), miss run length, sticky fault.
  int m_mode;
  int m_run;
  bit m_fault;

  typedef struct {
    logic [5:0] ctl;
    int         nxt;
  } exp_t;

  pipe_hazard_ctrl #(.REG_AW(3), .MISS_TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_hit   (icache_hit),
    .dcache_hit   (dcache_hit),
    .mem_access   (mem_access),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .branch_taken (branch_taken),
    .pc_we        (pc_we),
    .if_id_we     (if_id_we),
    .ex_mem_we    (ex_mem_we),
    .mem_wb_we    (mem_wb_we),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .state        (state),
    .miss_fault   (miss_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ctl_obs();
    return {pc_we, if_id_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Priority rules applied to the current inputs and model mode.
  function automatic exp_t model_eval();
    exp_t e;
    bit   lu;
    lu = ex_mem_read && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    if (m_mode == 2) begin
      e.ctl = dcache_hit ? E_GO : E_FREEZE;
      e.nxt = dcache_hit ? 0 : 2;
    end else if (mem_access && !dcache_hit) begin
      e.ctl = E_FREEZE; e.nxt = 2;
    end else if (branch_taken) begin
      e.ctl = E_REDIR;  e.nxt = 0;
    end else if (lu) begin
      e.ctl = E_LU;     e.nxt = m_mode;
    end else if (!icache_hit) begin
      e.ctl = E_FETCH;  e.nxt = 1;
    end else begin
      e.ctl = E_GO;     e.nxt = 0;
    end
    return e;
  endfunction

  task automatic idle_inputs();
    icache_hit = 1'b1; dcache_hit = 1'b1; mem_access = 1'b0;
    ex_mem_read = 1'b0; branch_taken = 1'b0;
    ex_rd = 3'd0; id_rs1 = 3'd1; id_rs2 = 3'd2;
  endtask

  // One clock cycle with the inputs already applied; checks against the
  // model at the falling edge and returns what was seen.
  task automatic step(output logic [5:0] seen, output logic [1:0] seen_st,
                      output logic seen_f);
    exp_t e;
    e = model_eval();
    @(negedge clk);
    seen    = ctl_obs();
    seen_st = state;
    seen_f  = miss_fault;
    chk("model_ctl",   16'(seen),    16'(e.ctl));
    chk("model_state", 16'(seen_st), 16'(m_mode));
    chk("model_fault", 16'(seen_f),  16'(m_fault));
    @(posedge clk);
    m_mode = e.nxt;
    m_run  = (e.nxt != 0) ? m_run + 1 : 0;
    if (m_run >= TIMEOUT) m_fault = 1'b1;
    #1;
  endtask

  // Asynchronous reset pulse, entered a little after a rising edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_ctl"},   16'(ctl_obs()),  16'(E_RESET));
    chk({tag, "_state"}, 16'(state),      16'd0);
    chk({tag, "_fault"}, 16'(miss_fault), 16'd0);
    m_mode = 0; m_run = 0; m_fault = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] s;
    logic [1:0] st;
    logic       f;

    idle_inputs();
    do_reset("reset");
    step(s, st, f);
    chk("run_idle", 16'(s), 16'(E_GO));

    // Load-use on rs2: one stall cycle, then free running.
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd5; id_rs2 = 3'd3;
    step(s, st, f);
    chk("lu_stall", 16'(s), 16'(E_LU));
    idle_inputs();
    step(s, st, f);
    chk("lu_after", 16'(s), 16'(E_GO));

    // Data miss for 4 cycles, then hit.
    mem_access = 1'b1; dcache_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(s, st, f);
      chk("dmiss_ctl",   16'(s),  16'(E_FREEZE));
      chk("dmiss_state", 16'(st), (k == 1) ? 16'd0 : 16'd2);
    end
    dcache_hit = 1'b1;
    step(s, st, f);
    chk("dmiss_hit_ctl",   16'(s),  16'(E_GO));
    chk("dmiss_hit_state", 16'(st), 16'd2);
    idle_inputs();
    step(s, st, f);
    chk("dmiss_exit_state", 16'(st), 16'd0);

    // Branch on the second cycle of an instruction miss.
    icache_hit = 1'b0;
    step(s, st, f);
    chk("imiss_ctl", 16'(s), 16'(E_FETCH));
    branch_taken = 1'b1;
    step(s, st, f);
    chk("imiss_br_ctl",   16'(s),  16'(E_REDIR));
    chk("imiss_br_state", 16'(st), 16'd1);
    idle_inputs();
    step(s, st, f);
    chk("imiss_br_exit", 16'(st), 16'd0);

    // Data miss, branch and load-use together: data miss wins.
    mem_access = 1'b1; dcache_hit = 1'b0; branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 3'd4; id_rs1 = 3'd4;
    step(s, st, f);
    chk("simul_ctl", 16'(s), 16'(E_FREEZE));
    dcache_hit = 1'b1; ex_mem_read = 1'b0;
    step(s, st, f);
    chk("simul_hit", 16'(s), 16'(E_GO));
    mem_access = 1'b0;
    step(s, st, f);
    chk("simul_branch", 16'(s), 16'(E_REDIR));
    idle_inputs();
    step(s, st, f);

    // Watchdog: fault shows on the 8th cycle spent in the miss state.
    mem_access = 1'b1; dcache_hit = 1'b0;
    step(s, st, f);
    for (int k = 1; k <= 10; k++) begin
      step(s, st, f);
      chk("wd_fault", 16'(f), (k >= TIMEOUT) ? 16'd1 : 16'd0);
    end
    dcache_hit = 1'b1;
    step(s, st, f);
    idle_inputs();
    step(s, st, f);
    chk("wd_sticky", 16'(f), 16'd1);
    do_reset("wd_reset");
    step(s, st, f);
    chk("wd_cleared", 16'(f), 16'd0);

    // Reset in the middle of an instruction miss.
    icache_hit = 1'b0;
    step(s, st, f);
    step(s, st, f);
    chk("mid_imiss_state", 16'(st), 16'd1);
    do_reset("mid_miss_reset");
    step(s, st, f);
    chk("post_reset_run", 16'(s), 16'(E_GO));

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rand_reset");
      end
      mem_access   = ($urandom_range(0, 3) == 0);
      dcache_hit   = ($urandom_range(0, 2) != 0);
      icache_hit   = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_rd        = 3'($urandom_range(0, 7));
      id_rs1       = 3'($urandom_range(0, 7));
      id_rs2       = 3'($urandom_range(0, 7));
      step(s, st, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
